// File: rtl/if_pkg.sv
// Shared constants and helpers for the fetch stage and its queue.
// Purely declarative; no logic lives here.
package if_pkg;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // A queue entry is {pc, instr}, so it is twice the datapath width.
   function automatic int entry_w(input int nbits);
      return 2 * nbits;
   endfunction

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: DEPTH-entry circular buffer with push/pop/flush and occupancy count.
// Latency: pushed entry visible at head the edge after push; head is combinational.
// Backpressure: caller must not push when full unless it pops the same cycle.
module fetch_fifo
   import if_pkg::*;
#(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  push,
   input  logic [W-1:0]          push_dat,
   input  logic                  pop,
   input  logic                  flush,
   output logic [W-1:0]          head_dat,
   output logic [clog2(DEPTH):0] count,
   output logic                  full,
   output logic                  empty
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign head_dat = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Purpose: PC register, redirect handling and instruction memory feeding a fetch queue to ID.
// Latency: push at edge N appears at the head after edge N; redirect target reaches ID 2 edges later.
// Backpressure: i_id_ready low stalls pops; fetch pushes only while the queue has room or pops.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int               NBITS     = 32,
   parameter int               TAM_I     = 256,
   parameter int               DEPTH     = 4,
   parameter logic [NBITS-1:0] HALT_WORD = NBITS'(if_pkg::HALT_WORD)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_step,
   input  logic                  i_load_we,
   input  logic [NBITS-1:0]      i_load_addr,
   input  logic [NBITS-1:0]      i_load_data,
   input  logic                  i_redirect,
   input  logic [NBITS-1:0]      i_redirect_pc,
   input  logic                  i_id_ready,
   output logic                  o_id_valid,
   output logic [NBITS-1:0]      o_instr,
   output logic [NBITS-1:0]      o_pc,
   output logic [NBITS-1:0]      o_pc4,
   output logic [NBITS-1:0]      o_pc8,
   output logic [clog2(DEPTH):0] o_count,
   output logic                  o_halted
);

   localparam int AW = clog2(TAM_I);
   localparam int EW = entry_w(NBITS);

   logic [NBITS-1:0] imem [TAM_I/4];
   logic [NBITS-1:0] fetch_pc;
   logic [NBITS-1:0] fetch_word;
   logic             halted;
   logic             push;
   logic             pop;
   logic             flush;
   logic             fifo_full;
   logic             fifo_empty;
   logic [EW-1:0]    head_dat;
   logic [NBITS-1:0] head_pc;
   logic [NBITS-1:0] head_instr;
   logic             unused_bits;

   // Byte-lane and out-of-range address bits are don't-care: memory is word-addressed and wraps.
   assign unused_bits = ^{fetch_pc[NBITS-1:AW], fetch_pc[1:0],
                          i_load_addr[NBITS-1:AW], i_load_addr[1:0]};

   assign fetch_word = imem[fetch_pc[AW-1:2]];

   assign pop   = i_step & ~fifo_empty & i_id_ready;
   assign flush = i_step & i_redirect;
   assign push  = i_step & ~i_redirect & ~halted & ~i_load_we & (~fifo_full | pop);

   always_ff @(posedge i_clk) begin
      if (i_load_we) imem[i_load_addr[AW-1:2]] <= i_load_data;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         fetch_pc <= '0;
         halted   <= 1'b0;
      end else if (flush) begin
         fetch_pc <= i_redirect_pc;
         halted   <= 1'b0;
      end else if (push) begin
         fetch_pc <= fetch_pc + NBITS'(4);
         if (fetch_word == HALT_WORD) halted <= 1'b1;
      end
   end

   fetch_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .push     (push),
      .push_dat ({fetch_pc, fetch_word}),
      .pop      (pop),
      .flush    (flush),
      .head_dat (head_dat),
      .count    (o_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign head_pc    = head_dat[EW-1:NBITS];
   assign head_instr = head_dat[NBITS-1:0];

   assign o_id_valid = ~fifo_empty;
   assign o_halted   = halted;
   assign o_instr    = fifo_empty ? NBITS'(NOP_WORD) : head_instr;
   assign o_pc       = head_pc;
   assign o_pc4      = fifo_empty ? '0 : head_pc + NBITS'(4);
   assign o_pc8      = fifo_empty ? '0 : head_pc + NBITS'(8);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a reference queue scoreboard.
module tb_if_fetch_queue;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_step;
   logic        i_load_we;
   logic [31:0] i_load_addr;
   logic [31:0] i_load_data;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        i_id_ready;
   logic        o_id_valid;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic [31:0] o_pc4;
   logic [31:0] o_pc8;
   logic [2:0]  o_count;
   logic        o_halted;

   ent_t        sb [$];
   logic [31:0] m_mem [64];
   logic [31:0] m_pc;
   bit          m_halted;
   int          n_chk = 0;
   int          n_fail = 0;
   ent_t        frz;

   always #5 i_clk = ~i_clk;

   if_fetch_queue dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_step        (i_step),
      .i_load_we     (i_load_we),
      .i_load_addr   (i_load_addr),
      .i_load_data   (i_load_data),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_id_ready    (i_id_ready),
      .o_id_valid    (o_id_valid),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .o_pc4         (o_pc4),
      .o_pc8         (o_pc8),
      .o_count       (o_count),
      .o_halted      (o_halted)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1: decides model actions from current inputs, checks any
   // handshake against the scoreboard head, advances one edge, then checks state.
   task automatic tick();
      bit   pop_m, push_m, flush_m;
      ent_t e;
      logic [31:0] w;
      flush_m = i_step && i_redirect;
      pop_m   = i_step && (sb.size() > 0) && i_id_ready;
      push_m  = i_step && !i_redirect && !m_halted && !i_load_we && ((sb.size() < 4) || pop_m);
      if (pop_m && !flush_m) begin
         e = sb[0];
         chk("pop_pc",    64'(o_pc),    64'(e.pc));
         chk("pop_instr", 64'(o_instr), 64'(e.instr));
         chk("pop_pc4",   64'(o_pc4),   64'(e.pc + 32'd4));
         chk("pop_pc8",   64'(o_pc8),   64'(e.pc + 32'd8));
      end
      @(posedge i_clk);
      if (flush_m) begin
         sb.delete();
         m_pc     = i_redirect_pc;
         m_halted = 1'b0;
      end else begin
         if (pop_m) void'(sb.pop_front());
         if (push_m) begin
            w = m_mem[m_pc[7:2]];
            e.pc    = m_pc;
            e.instr = w;
            sb.push_back(e);
            m_pc = m_pc + 32'd4;
            if (w == 32'hFFFF_FFFF) m_halted = 1'b1;
         end
      end
      if (i_load_we) m_mem[i_load_addr[7:2]] = i_load_data;
      #1;
      chk("count",  64'(o_count),    64'(sb.size()));
      chk("valid",  64'(o_id_valid), 64'(sb.size() != 0));
      chk("halted", 64'(o_halted),   64'(m_halted));
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data);
      i_load_we   = 1'b1;
      i_load_addr = addr;
      i_load_data = data;
      tick();
      i_load_we   = 1'b0;
   endtask

   task automatic redirect_to(input logic [31:0] target);
      i_redirect    = 1'b1;
      i_redirect_pc = target;
      tick();
      i_redirect    = 1'b0;
   endtask

   initial begin
      i_reset = 1'b0; i_step = 1'b0; i_load_we = 1'b0; i_load_addr = '0;
      i_load_data = '0; i_redirect = 1'b0; i_redirect_pc = '0; i_id_ready = 1'b0;
      m_pc = '0; m_halted = 1'b0;
      #12;
      chk("rst_valid",  64'(o_id_valid), 64'(0));
      chk("rst_instr",  64'(o_instr),    64'(0));
      chk("rst_pc",     64'(o_pc),       64'(0));
      chk("rst_pc4",    64'(o_pc4),      64'(0));
      chk("rst_pc8",    64'(o_pc8),      64'(0));
      chk("rst_count",  64'(o_count),    64'(0));
      chk("rst_halted", 64'(o_halted),   64'(0));
      @(posedge i_clk); #1;
      i_reset = 1'b1;

      for (int i = 0; i < 64; i++) load(32'(i * 4), 32'((i + 1) * 11));

      // Streaming with ID always ready
      i_step = 1'b1; i_id_ready = 1'b1;
      tick();
      chk("first_instr", 64'(o_instr), 64'(11));
      chk("first_pc",    64'(o_pc),    64'(0));
      chk("first_pc8",   64'(o_pc8),   64'(8));
      repeat (6) tick();

      // Stall fills the queue, then pop+push while full
      redirect_to(32'h0);
      chk("flush_count", 64'(o_count), 64'(0));
      i_id_ready = 1'b0;
      repeat (10) tick();
      chk("sat_count", 64'(o_count), 64'(4));
      i_id_ready = 1'b1;
      tick();
      chk("full_pp_count", 64'(o_count), 64'(4));
      chk("full_pp_head",  64'(o_pc),    64'(4));
      repeat (6) tick();

      // Redirect with three entries queued
      redirect_to(32'h0);
      i_id_ready = 1'b0;
      repeat (3) tick();
      chk("pre_redir_count", 64'(o_count), 64'(3));
      i_id_ready = 1'b1;
      redirect_to(32'h40);
      chk("redir_count", 64'(o_count),    64'(0));
      chk("redir_valid", 64'(o_id_valid), 64'(0));
      tick();
      chk("redir_pc",    64'(o_pc),    64'(32'h40));
      chk("redir_instr", 64'(o_instr), 64'(187));
      repeat (4) tick();

      // Halt word at word 2
      load(32'h8, 32'hFFFF_FFFF);
      redirect_to(32'h0);
      repeat (8) tick();
      chk("halt_set",   64'(o_halted), 64'(1));
      chk("halt_drain", 64'(o_count),  64'(0));
      redirect_to(32'h0);
      chk("halt_clear", 64'(o_halted), 64'(0));
      repeat (2) tick();
      load(32'h8, 32'd33);
      redirect_to(32'h0);

      // Freeze with i_step low; redirect and ready must be ignored
      i_id_ready = 1'b0;
      repeat (3) tick();
      frz = sb[0];
      i_id_ready = 1'b1; i_step = 1'b0;
      i_redirect = 1'b1; i_redirect_pc = 32'h80;
      repeat (5) begin
         tick();
         chk("frz_pc",    64'(o_pc),    64'(frz.pc));
         chk("frz_instr", 64'(o_instr), 64'(frz.instr));
         chk("frz_count", 64'(o_count), 64'(3));
      end
      i_redirect = 1'b0; i_step = 1'b1;
      repeat (4) tick();

      // Asynchronous reset pulse mid-stream
      @(posedge i_clk); #3;
      i_reset = 1'b0;
      #1;
      chk("arst_valid", 64'(o_id_valid), 64'(0));
      chk("arst_pc",    64'(o_pc),       64'(0));
      chk("arst_count", 64'(o_count),    64'(0));
      sb.delete(); m_pc = '0; m_halted = 1'b0;
      #1;
      i_reset = 1'b1;
      tick();
      chk("post_rst_instr", 64'(o_instr), 64'(11));
      repeat (6) tick();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
